mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the hart's MMIO write path, downstream of the data-memory store path.
- Consumes the mem_write_control_t bundle driven by the data memory block.
- Returns the write-complete handshake that gates the hart's writeback stage.
- Returns MMIO read data.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on a single tx line.

---
 rtl/mmio_uart_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA writes queue bytes in a FIFO, STATUS reports full/busy/empty,
// bytes leave LSB first as 8N1 frames. Define MMIO_UART_TX_PARITY_EN to add an even-parity bit before stop.

typedef struct packed {
    logic        enable;
    logic [31:0] addr;
    logic [31:0] value;
    logic [1:0]  width;
} mem_write_control_t;

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0003_0000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  mem_write_control_t mmio_control,
    input  logic [31:0]        mmio_r_addr,
    output logic [31:0]        mmio_r_data,
    output logic               mmio_write_complete,
    output logic               tx
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    logic [7:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic              w_in_block;
    logic              w_req;
    logic              w_is_txdata;
    logic              r_in_block;
    logic              fifo_full;
    logic              fifo_empty;
    logic              busy;
    logic              push;
    logic              pop;
    logic              baud_done;

    // Only the low byte of the store matters; width and upper data bits are ignored.
    logic              unused_wr_bits;
    assign unused_wr_bits = ^{mmio_control.width, mmio_control.value[31:8]};

    assign w_in_block  = (mmio_control.addr[31:3] == BASE_ADDR[31:3]);
    assign w_req       = mmio_control.enable && w_in_block;
    assign w_is_txdata = (mmio_control.addr[2:0] == 3'd0);
    assign r_in_block  = (mmio_r_addr[31:3] == BASE_ADDR[31:3]);

    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign busy       = !fifo_empty || (state_q != S_IDLE);

    // Full looks at the registered count only, so a pop this cycle cannot admit a push this cycle.
    assign push = w_req && w_is_txdata && !fifo_full;
    assign mmio_write_complete = reset && w_req && (!w_is_txdata || !fifo_full);

    always_comb begin
        mmio_r_data = '0;
        if (r_in_block && (mmio_r_addr[2:0] == 3'd4)) begin
            mmio_r_data[2:0] = {fifo_empty, busy, fifo_full};
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mmio_control.value[7:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign baud_done = (baud_q == '0);

    // tx_d always carries the level of the bit being entered, so tx is a clean register output.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        baud_d    = (state_q == S_IDLE) ? baud_q : baud_q - BAUD_W'(1);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    state_d = S_START;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d   = S_DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit so queued frames stay contiguous.
                        pop     = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        state_d = S_START;
                        baud_d  = BAUD_RELOAD;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        baud_d  = '0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register handshake, FIFO back-pressure, frame timing and async reset.
`timescale 1ns/1ps

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0003_0000;
    localparam int CPB = 16;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    mem_write_control_t mmio_control;
    logic [31:0]        mmio_r_addr;
    logic [31:0]        mmio_r_data;
    logic               mmio_write_complete;
    logic               tx;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int k;
    int stall;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       framed;
        int         start;
    } frame_t;

    frame_t     rx_q[$];
    frame_t     f;
    logic [7:0] vals [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h96, 8'h69};

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mmio_control       (mmio_control),
        .mmio_r_addr        (mmio_r_addr),
        .mmio_r_data        (mmio_r_data),
        .mmio_write_complete(mmio_write_complete),
        .tx                 (tx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Serial receiver: every bit must hold one level for CPB cycles; start low, stop high.
    initial begin : rx_monitor
        logic             active;
        logic             stable;
        int               pos;
        int               start;
        logic [NBITS-1:0] bits;
        active = 1'b0;
        stable = 1'b1;
        pos    = 0;
        start  = 0;
        bits   = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    pos    = 1;
                    start  = cyc;
                    bits   = '0;
                    stable = 1'b1;
                end
            end else begin
                if (pos % CPB == 0) bits[pos / CPB] = tx;
                else if (tx !== bits[pos / CPB]) stable = 1'b0;
                pos++;
                if (pos == FRAME) begin
                    rx_q.push_back('{data: bits[8:1], par: bits[NBITS-2],
                                     framed: stable && bits[NBITS-1] && !bits[0], start: start});
                    active = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_write(input logic [31:0] addr, input logic [31:0] value, input logic [1:0] width);
        mmio_control.enable = 1'b1;
        mmio_control.addr   = addr;
        mmio_control.value  = value;
        mmio_control.width  = width;
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int waited;
        waited = 0;
        while (rx_q.size() < n && waited < budget) begin
            tick();
            waited++;
        end
        check(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    initial begin : stimulus
        mmio_control = '0;
        mmio_r_addr  = BASE + 32'd4;
        reset        = 1'b0;
        repeat (3) tick();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_status", mmio_r_data, 32'h4);

        reset = 1'b1;
        repeat (100) tick();
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_status", mmio_r_data, 32'h4);
        check("idle_wc", 32'(mmio_write_complete), 32'd0);
        check("idle_no_frames", 32'(rx_q.size()), 32'd0);
        mmio_r_addr = BASE;
        #1 check("read_txdata_zero", mmio_r_data, 32'h0);
        mmio_r_addr = BASE + 32'd12;
        #1 check("read_oob_zero", mmio_r_data, 32'h0);
        mmio_r_addr = BASE + 32'd4;
        tick();

        // Single word write of 0xA5: start bit two cycles after acceptance.
        k = cyc;
        set_write(BASE, 32'h0000_00A5, 2'b10);
        check("a5_wc", 32'(mmio_write_complete), 32'd1);
        tick();
        mmio_control = '0;
        #1;
        check("a5_status_k1", mmio_r_data, 32'h2);
        check("a5_tx_k1", 32'(tx), 32'd1);
        tick();
        check("a5_tx_k2", 32'(tx), 32'd0);
        wait_frames(1, FRAME + 20, "a5_frame_seen");
        check("a5_status_after", mmio_r_data, 32'h4);
        f = rx_q.pop_front();
        check("a5_data", 32'(f.data), 32'hA5);
        check("a5_framed", 32'(f.framed), 32'd1);
        check("a5_start", 32'(f.start), 32'(k + 2));

        // Non-TXDATA offsets and disabled writes.
        set_write(BASE + 32'd4, 32'h55, 2'b10);
        check("wr_status_wc", 32'(mmio_write_complete), 32'd1);
        tick();
        set_write(BASE + 32'd12, 32'h55, 2'b10);
        check("wr_oob_wc", 32'(mmio_write_complete), 32'd0);
        tick();
        mmio_control.enable = 1'b0;
        mmio_control.addr   = BASE;
        #1 check("wr_disabled_wc", 32'(mmio_write_complete), 32'd0);
        tick();
        mmio_control = '0;
        repeat (40) tick();
        check("offsets_status", mmio_r_data, 32'h4);
        check("offsets_tx", 32'(tx), 32'd1);
        check("offsets_no_frames", 32'(rx_q.size()), 32'd0);

        // Nine back-to-back pushes fill the FIFO; the tenth stalls until the first frame's stop pop.
        k = cyc;
        for (int i = 0; i < 9; i++) begin
            set_write(BASE, {24'hDEADBE, vals[i]}, 2'(i % 3));
            check($sformatf("b2b_wc%0d", i), 32'(mmio_write_complete), 32'd1);
            tick();
        end
        set_write(BASE, {24'h123456, vals[9]}, 2'b00);
        check("b2b_full_wc", 32'(mmio_write_complete), 32'd0);
        check("b2b_full_status", mmio_r_data, 32'h3);
        stall = 0;
        while (mmio_write_complete !== 1'b1 && stall < 400) begin
            tick();
            stall++;
        end
        check("b2b_stall_cycles", 32'(stall), 32'(FRAME - 7));
        tick();
        mmio_control = '0;
        wait_frames(10, 10 * FRAME + 100, "b2b_frames_seen");
        for (int i = 0; i < 10; i++) begin
            f = rx_q.pop_front();
            check($sformatf("b2b_data%0d", i), 32'(f.data), 32'(vals[i]));
            check($sformatf("b2b_framed%0d", i), 32'(f.framed), 32'd1);
            check($sformatf("b2b_start%0d", i), 32'(f.start), 32'(k + 2 + i * FRAME));
        end
        check("b2b_status_after", mmio_r_data, 32'h4);

        // Reset while bit 1 (a zero) of 0x3C is on the line, with three more bytes queued.
        k = cyc;
        set_write(BASE, 32'h3C, 2'b00);
        check("rst_wc0", 32'(mmio_write_complete), 32'd1);
        tick();
        set_write(BASE, 32'h11, 2'b00);
        check("rst_wc1", 32'(mmio_write_complete), 32'd1);
        tick();
        set_write(BASE, 32'h22, 2'b00);
        check("rst_wc2", 32'(mmio_write_complete), 32'd1);
        tick();
        set_write(BASE, 32'h33, 2'b00);
        check("rst_wc3", 32'(mmio_write_complete), 32'd1);
        tick();
        mmio_control = '0;
        repeat (36) tick();
        check("rst_mid_data_tx", 32'(tx), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        check("rst_async_status", mmio_r_data, 32'h4);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2 * FRAME) tick();
        check("rst_after_status", mmio_r_data, 32'h4);
        check("rst_after_tx", 32'(tx), 32'd1);
        check("rst_no_frames", 32'(rx_q.size()), 32'd0);

`ifdef MMIO_UART_TX_PARITY_EN
        k = cyc;
        set_write(BASE, 32'h07, 2'b00);
        tick();
        set_write(BASE, 32'h03, 2'b00);
        tick();
        mmio_control = '0;
        wait_frames(2, 2 * FRAME + 50, "par_frames_seen");
        f = rx_q.pop_front();
        check("par07_data", 32'(f.data), 32'h07);
        check("par07_bit", 32'(f.par), 32'd1);
        check("par07_framed", 32'(f.framed), 32'd1);
        f = rx_q.pop_front();
        check("par03_data", 32'(f.data), 32'h03);
        check("par03_bit", 32'(f.par), 32'd0);
        check("par03_start", 32'(f.start), 32'(k + 2 + 176));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
